// File: rtl/adder.sv
// 32-bit carry-lookahead adder with registered sum, carry-out and signed
// overflow. Eight 4-bit CLA groups feed a second-level lookahead across the
// groups. The result appears on the outputs one clock after the operands
// are sampled.
module adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] out,
  output logic        carry_out,
  output logic        overflow
);

  localparam int unsigned GROUP_W    = 4;
  localparam int unsigned NUM_GROUPS = 8;

  logic [31:0]           p;       // bit propagate
  logic [31:0]           g;       // bit generate
  logic [NUM_GROUPS-1:0] grp_p;   // group propagate
  logic [NUM_GROUPS-1:0] grp_g;   // group generate
  logic [NUM_GROUPS:0]   grp_c;   // carry into each group; grp_c[8] is c[32]
  logic [32:0]           c;       // carry into each bit

  logic [31:0] out_d, out_q;
  logic        carry_out_d, carry_out_q;
  logic        overflow_d, overflow_q;

  // Bit-level propagate and generate terms.
  always_comb begin
    p = input1 ^ input2;
    g = input1 & input2;
  end

  // Group-level propagate and generate for each 4-bit slice.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NUM_GROUPS; j++) begin
      grp_p[j] = &p[GROUP_W*j +: GROUP_W];
      grp_g[j] = g[GROUP_W*j+3]
               | (p[GROUP_W*j+3] & g[GROUP_W*j+2])
               | (p[GROUP_W*j+3] & p[GROUP_W*j+2] & g[GROUP_W*j+1])
               | (p[GROUP_W*j+3] & p[GROUP_W*j+2] & p[GROUP_W*j+1] & g[GROUP_W*j]);
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products of
  // lower group generates and intervening group propagates, so no carry
  // ripples from one group to the next. Carry into bit 0 is zero.
  always_comb begin
    logic acc;
    logic term;
    // NOTE: every variable written here gets a value on every path first, so
    // no latch is inferred.
    grp_c = '0;
    acc   = 1'b0;
    term  = 1'b0;
    for (int j = 1; j <= NUM_GROUPS; j++) begin
      acc = 1'b0;
      for (int k = 0; k < j; k++) begin
        term = grp_g[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      grp_c[j] = acc;
    end
  end

  // Bit carries inside each group, looked ahead from the group carry-in.
  always_comb begin
    logic acc;
    logic term;
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int j = 0; j < NUM_GROUPS; j++) begin
      c[GROUP_W*j] = grp_c[j];
      for (int i = 1; i < GROUP_W; i++) begin
        // Path from the group carry-in through all lower bits of the group.
        acc = grp_c[j];
        for (int m = 0; m < i; m++) begin
          acc = acc & p[GROUP_W*j+m];
        end
        // Paths from each generate inside the group.
        for (int k = 0; k < i; k++) begin
          term = g[GROUP_W*j+k];
          for (int m = k + 1; m < i; m++) begin
            term = term & p[GROUP_W*j+m];
          end
          acc = acc | term;
        end
        c[GROUP_W*j+i] = acc;
      end
    end
    c[32] = grp_c[NUM_GROUPS];
  end

  // Sum and flags for the output registers.
  always_comb begin
    out_d       = p ^ c[31:0];
    carry_out_d = c[32];
    overflow_d  = c[31] ^ c[32];
  end

  // Output registers load every cycle; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      out_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out       = out_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the registered 32-bit CLA adder: directed corner
// cases, back-to-back random operands against an arithmetic reference, and
// asynchronous reset behaviour.
module tb_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;
  logic        carry_out;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input1    (input1),
    .input2    (input2),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed {carry_out, overflow, out} against the expected value.
  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got c=%0b v=%0b out=%08h, expected c=%0b v=%0b out=%08h",
               tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Reference: unsigned 33-bit sum for carry, wide signed sum for overflow.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] u;
    longint      s;
    logic        v;
    u = {1'b0, a} + {1'b0, b};
    s = longint'($signed(a)) + longint'($signed(b));
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {u[32], v, u[31:0]};
  endfunction

  function automatic logic [33:0] observed();
    return {carry_out, overflow, out};
  endfunction

  // Drive operands, take one edge, and check the registered result.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
    input1 = a;
    input2 = b;
    @(posedge clk);
    #1;
    check(tag, observed(), model(a, b));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = 32'hFFFF_FFFF - {28'h0, r[3:0]};
      1: r = 32'h7FFF_FFFF + {28'h0, r[3:0]};
      2: r = {r[31:16], 16'hFFFF};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [33:0] held;
    logic [31:0] a;
    logic [31:0] b;

    // Reset held low: outputs stay cleared across clock edges.
    rst_n  = 1'b0;
    input1 = 32'd5;
    input2 = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observed(), 34'h0);

    // First edge after release loads the current operands' result.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", observed(), {2'b00, 32'd12});

    // Directed sums and boundaries.
    apply("zero",         32'd0,          32'd0);
    apply("zero_plus_10", 32'd0,          32'd10);
    apply("basic_1010",   32'd1000,       32'd10);
    apply("uns_wrap",     32'hFFFF_FFFF,  32'h1);
    apply("sgn_ovf_pos",  32'h7FFF_FFFF,  32'h1);
    apply("sgn_ovf_neg",  32'h8000_0000,  32'h8000_0000);
    apply("carry_16",     32'h0000_FFFF,  32'h1);
    apply("carry_28",     32'h0FFF_FFFF,  32'h1);
    apply("neg1_neg1",    32'hFFFF_FFFF,  32'hFFFF_FFFF);
    apply("alt_bits",     32'hAAAA_AAAA,  32'h5555_5555);
    apply("alt_bits_c",   32'hAAAA_AAAB,  32'h5555_5555);

    // Constants the reference must agree with, checked independently.
    input1 = 32'h7FFF_FFFF;
    input2 = 32'h1;
    @(posedge clk);
    #1;
    check("const_ovf", observed(), {1'b0, 1'b1, 32'h8000_0000});

    // Operand changes between edges must not reach the outputs.
    held   = observed();
    input1 = 32'h1234_5678;
    input2 = 32'h1111_1111;
    #2;
    check("hold_between_edges", observed(), held);

    // Back-to-back random operands, one new pair every cycle.
    for (int i = 0; i < 10000; i++) begin
      a = rand_operand();
      b = rand_operand();
      apply("random", a, b);
    end

    // Assert reset mid-cycle: outputs clear before any clock edge.
    input1 = 32'hFFFF_FFFF;
    input2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), 34'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_2", observed(), 34'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_2", observed(), model(32'hFFFF_FFFF, 32'hFFFF_FFFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
